trade_executor: RTL and testbench
=================================

Name: trade_executor

Overview:
Consumer at the far end of the SMA trade-signal path. Samples the 2-bit trade signal together with the current price and checks each request against position and cash limits. Accepted requests become a single order, issued to a downstream broker interface over a valid/ready handshake. Tracks position and cash, and enforces a cooldown between fills.

Parameters:
DATA_WIDTH, 8, price width; matches the SMA price path.
CASH_WIDTH, 16, unsigned cash accumulator width; must be greater than DATA_WIDTH.
INIT_CASH, 1000, cash value loaded on reset.
MAX_POSITION, 4, maximum units held; the position never exceeds this.
COOLDOWN_CYCLES, 8, idle cycles after each fill; 0 means no cooldown.
TIMEOUT_CYCLES, 16, handshake timeout; used only when ORDER_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
price_in  input  DATA_WIDTH  current price
price_valid_in  input  1  price_in and trade_signal_in are valid this cycle
trade_signal_in  input  2  00 hold, 01 buy, 10 sell, 11 reserved (treated as hold)
order_valid_out  output  1  order pending toward broker
order_ready_in  input  1  broker accepts the order
order_side_out  output  1  0 buy, 1 sell
order_price_out  output  DATA_WIDTH  price captured at request time
position_out  output  $clog2(MAX_POSITION+1)  units currently held
cash_out  output  CASH_WIDTH  current cash
busy_out  output  1  high whenever the state is not IDLE
reject_count_out  output  8  count of rejected requests, saturating

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); every register is updated on the rising edge of clk.
- Reset values: order_valid_out=0, order_side_out=0, order_price_out=0, position_out=0, cash_out=INIT_CASH, busy_out=0, reject_count_out=0, state=IDLE.
- FSM states: IDLE, ISSUE, COOLDOWN.
- IDLE: a request is sampled on an edge where price_valid_in=1 and trade_signal_in is 01 or 10.
  - Buy is accepted iff position<MAX_POSITION and cash>=zero-extended price_in.
  - Sell is accepted iff position>0.
  - Accepted request: capture side and price_in; order_valid_out=1 from the next cycle; state goes to ISSUE.
  - Rejected request: reject_count increments, saturating at 255; state stays IDLE.
  - Hold (00) and reserved (11): no action.
- ISSUE:
  - order_valid_out, order_side_out and order_price_out are held stable until order_valid_out && order_ready_in.
  - On the handshake edge:
    - Buy: position+1, cash-price.
    - Sell: position-1, cash+price, saturating at 2^CASH_WIDTH-1.
    - order_valid_out=0 from the next cycle.
    - Next state is COOLDOWN, or IDLE directly if COOLDOWN_CYCLES=0.
- Timing:
  - Request to order_valid_out: latency 1 cycle.
  - With ready already high, the handshake completes in the first valid cycle, so position/cash update 2 cycles after the request edge.
- COOLDOWN: a down-counter loaded with COOLDOWN_CYCLES-1 on entry; the state returns to IDLE when the counter reaches 0. This gives exactly COOLDOWN_CYCLES cycles in COOLDOWN.
- Requests arriving in ISSUE or COOLDOWN are dropped silently. They are not counted and not queued.
- order_ready_in while order_valid_out=0 is ignored.
- Cash check uses the captured price. Cash cannot underflow because a buy is only accepted when cash>=price.
- Reset mid-ISSUE: the pending order is abandoned with no fill. Position and cash return to their reset values in the same cycle.
- position_out, cash_out and reject_count_out are registered outputs.

Optional Feature:
Macro ORDER_TIMEOUT_EN.
- Defined:
  - ISSUE runs a counter starting at 0.
  - If TIMEOUT_CYCLES cycles pass without a handshake, order_valid_out drops, position and cash are unchanged, reject_count increments (saturating), and the state returns to IDLE with no cooldown.
  - A handshake on the final cycle wins over the timeout.
- Not defined: ISSUE waits indefinitely for order_ready_in.

Test Plan:
- Reset, then idle: all outputs at reset values, cash_out=1000, busy_out=0.
- Buy at price 100 with ready tied high: order_valid_out=1 for 1 cycle with side=0, price=100. Then position=1, cash=900, busy_out stays high for 8 cooldown cycles.
- Five buys at price 10, spaced past cooldown: positions 1..4. The fifth buy is rejected, reject_count=1, and no order is issued.
- Sell with position 0: rejected, reject_count increments. Buy at 100 then sell at 150: cash=1050, position=0.
- Ready held low for 20 cycles: valid, side and price stay stable throughout. A new buy signal during this time is dropped. Asserting ready completes the single fill.
- ORDER_TIMEOUT_EN with ready never asserted: order_valid_out drops after 16 cycles, reject_count=1, position and cash unchanged. Also assert rst during ISSUE: next cycle has order_valid_out=0 and cash=1000.

Source files
------------

// File: rtl/trade_executor.sv
// trade_executor
//   Far-end consumer of the SMA trade-signal path. Samples a 2-bit trade
//   signal with the current price, checks each request against position and
//   cash limits, and issues accepted requests as one order to a broker over
//   a valid/ready handshake. Tracks position and cash and enforces a
//   cooldown after every fill.
//
//   Optional feature macro: ORDER_TIMEOUT_EN
//     defined   : an unanswered order is abandoned after TIMEOUT_CYCLES
//                 cycles in ISSUE and counted as a reject.
//     undefined : ISSUE waits indefinitely for order_ready_in.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   price_in          current price
//   price_valid_in    price_in / trade_signal_in valid this cycle
//   trade_signal_in   00 hold, 01 buy, 10 sell, 11 reserved (hold)
//   order_valid_out   order pending toward broker
//   order_ready_in    broker accepts the order
//   order_side_out    0 buy, 1 sell
//   order_price_out   price captured at request time
//   position_out      units currently held
//   cash_out          current cash
//   busy_out          state is not IDLE
//   reject_count_out  saturating count of rejected requests
module trade_executor #(
    parameter int DATA_WIDTH      = 8,
    parameter int CASH_WIDTH      = 16,
    parameter int INIT_CASH       = 1000,
    parameter int MAX_POSITION    = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             price_in,
    input  logic                              price_valid_in,
    input  logic [1:0]                        trade_signal_in,
    output logic                              order_valid_out,
    input  logic                              order_ready_in,
    output logic                              order_side_out,
    output logic [DATA_WIDTH-1:0]             order_price_out,
    output logic [$clog2(MAX_POSITION+1)-1:0] position_out,
    output logic [CASH_WIDTH-1:0]             cash_out,
    output logic                              busy_out,
    output logic [7:0]                        reject_count_out
);

    localparam int POS_W = $clog2(MAX_POSITION + 1);
    localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CD_W-1:0]       CD_INIT   = (COOLDOWN_CYCLES > 0) ? CD_W'(COOLDOWN_CYCLES - 1) : '0;
    localparam logic [POS_W-1:0]      POS_MAX   = POS_W'(MAX_POSITION);
    localparam logic [CASH_WIDTH-1:0] CASH_INIT = CASH_WIDTH'(INIT_CASH);

    typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;
    state_t state, state_nx;

    logic [CD_W-1:0]       cd_cnt;
    logic                  req_buy, req_sell, accept, reject, handshake, timeout_hit, cd_done;
    logic [CASH_WIDTH-1:0] price_ext, ord_price_ext;
    logic [CASH_WIDTH:0]   sell_sum;

    assign req_buy       = price_valid_in && (trade_signal_in == 2'b01);
    assign req_sell      = price_valid_in && (trade_signal_in == 2'b10);
    assign price_ext     = {{(CASH_WIDTH-DATA_WIDTH){1'b0}}, price_in};
    assign ord_price_ext = {{(CASH_WIDTH-DATA_WIDTH){1'b0}}, order_price_out};

    // Requests only count (accepted or rejected) while IDLE; elsewhere they
    // are dropped without trace.
    assign accept = (state == IDLE) &&
                    ((req_buy && (position_out < POS_MAX) && (cash_out >= price_ext)) ||
                     (req_sell && (position_out != '0)));
    assign reject    = (state == IDLE) && (req_buy || req_sell) && !accept;
    assign handshake = (state == ISSUE) && order_ready_in;
    assign cd_done   = (cd_cnt == '0);
    assign sell_sum  = {1'b0, cash_out} + {1'b0, ord_price_ext};

    assign order_valid_out = (state == ISSUE);
    assign busy_out        = (state != IDLE);

`ifdef ORDER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    // A handshake on the last allowed cycle takes priority over the timeout.
    assign timeout_hit = (state == ISSUE) && !order_ready_in &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ISSUE) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = ISSUE;
            ISSUE: begin
                if (handshake)        state_nx = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
                else if (timeout_hit) state_nx = IDLE;
            end
            COOLDOWN: if (cd_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            order_side_out   <= 1'b0;
            order_price_out  <= '0;
            position_out     <= '0;
            cash_out         <= CASH_INIT;
            reject_count_out <= '0;
            cd_cnt           <= '0;
        end else begin
            if (accept) begin
                order_side_out  <= req_sell;
                order_price_out <= price_in;
            end

            if (handshake) begin
                if (!order_side_out) begin
                    position_out <= position_out + POS_W'(1);
                    cash_out     <= cash_out - ord_price_ext;
                end else begin
                    position_out <= position_out - POS_W'(1);
                    cash_out     <= sell_sum[CASH_WIDTH] ? '1 : sell_sum[CASH_WIDTH-1:0];
                end
            end

            if ((reject || timeout_hit) && reject_count_out != 8'hFF)
                reject_count_out <= reject_count_out + 8'd1;

            // Loaded on the fill so COOLDOWN lasts exactly COOLDOWN_CYCLES.
            if (handshake)
                cd_cnt <= CD_INIT;
            else if (state == COOLDOWN && !cd_done)
                cd_cnt <= cd_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_trade_executor.sv
module tb_trade_executor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  price_in = '0;
    logic        price_valid_in = 1'b0;
    logic [1:0]  trade_signal_in = '0;
    logic        order_valid_out;
    logic        order_ready_in = 1'b0;
    logic        order_side_out;
    logic [7:0]  order_price_out;
    logic [2:0]  position_out;
    logic [15:0] cash_out;
    logic        busy_out;
    logic [7:0]  reject_count_out;

    int total = 0;
    int bad   = 0;

    trade_executor dut (
        .clk(clk), .rst(rst),
        .price_in(price_in), .price_valid_in(price_valid_in), .trade_signal_in(trade_signal_in),
        .order_valid_out(order_valid_out), .order_ready_in(order_ready_in),
        .order_side_out(order_side_out), .order_price_out(order_price_out),
        .position_out(position_out), .cash_out(cash_out), .busy_out(busy_out),
        .reject_count_out(reject_count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sig;
        logic [7:0]  price;
        logic        acc;
        logic [2:0]  pos;
        logic [15:0] cash;
        logic [7:0]  rej;
    } vec_t;

    typedef struct {
        logic       side;
        logic [7:0] price;
    } ord_t;

    ord_t sb[$];
    vec_t vecs[14];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(logic [1:0] s, logic [7:0] p, logic exp_acc);
        if (exp_acc) sb.push_back('{s == 2'b10, p});
        price_valid_in  = 1'b1;
        trade_signal_in = s;
        price_in        = p;
        tick();
        price_valid_in  = 1'b0;
        trade_signal_in = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        price_valid_in = 1'b0;
        trade_signal_in = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    // Scoreboard: every completed handshake must match the oldest expected order.
    always @(negedge clk) begin
        if (!rst && order_valid_out && order_ready_in) begin
            if (sb.size() == 0) begin
                chk("unexpected_order", 1, 0);
            end else begin
                ord_t o;
                o = sb.pop_front();
                chk("ord_side", order_side_out, o.side);
                chk("ord_price", order_price_out, o.price);
            end
        end
    end

    initial begin
        vecs[0]  = '{2'b01, 8'd100, 1'b1, 3'd1, 16'd900,  8'd0};
        vecs[1]  = '{2'b10, 8'd150, 1'b1, 3'd0, 16'd1050, 8'd0};
        vecs[2]  = '{2'b10, 8'd10,  1'b0, 3'd0, 16'd1050, 8'd1};
        vecs[3]  = '{2'b01, 8'd10,  1'b1, 3'd1, 16'd1040, 8'd1};
        vecs[4]  = '{2'b01, 8'd10,  1'b1, 3'd2, 16'd1030, 8'd1};
        vecs[5]  = '{2'b01, 8'd10,  1'b1, 3'd3, 16'd1020, 8'd1};
        vecs[6]  = '{2'b01, 8'd10,  1'b1, 3'd4, 16'd1010, 8'd1};
        vecs[7]  = '{2'b01, 8'd10,  1'b0, 3'd4, 16'd1010, 8'd2};
        vecs[8]  = '{2'b00, 8'd5,   1'b0, 3'd4, 16'd1010, 8'd2};
        vecs[9]  = '{2'b11, 8'd5,   1'b0, 3'd4, 16'd1010, 8'd2};
        vecs[10] = '{2'b10, 8'd200, 1'b1, 3'd3, 16'd1210, 8'd2};
        vecs[11] = '{2'b01, 8'd255, 1'b1, 3'd4, 16'd955,  8'd2};
        vecs[12] = '{2'b01, 8'd1,   1'b0, 3'd4, 16'd955,  8'd3};
        vecs[13] = '{2'b10, 8'd255, 1'b1, 3'd3, 16'd1210, 8'd3};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", order_valid_out, 0);
        chk("rst_side", order_side_out, 0);
        chk("rst_price", order_price_out, 0);
        chk("rst_pos", position_out, 0);
        chk("rst_cash", cash_out, 1000);
        chk("rst_busy", busy_out, 0);
        chk("rst_rej", reject_count_out, 0);

        // Buy at 100 with ready high: timing, fill, cooldown length, dropped request
        order_ready_in = 1'b1;
        req(2'b01, 8'd100, 1'b1);
        @(negedge clk);
        chk("b_valid", order_valid_out, 1);
        chk("b_side", order_side_out, 0);
        chk("b_price", order_price_out, 100);
        chk("b_busy", busy_out, 1);
        chk("b_pos_pre", position_out, 0);
        @(negedge clk);
        chk("b_valid_drop", order_valid_out, 0);
        chk("b_pos", position_out, 1);
        chk("b_cash", cash_out, 900);
        chk("b_cd_busy0", busy_out, 1);
        req(2'b01, 8'd5, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("b_cd_busy", busy_out, 1);
        end
        @(negedge clk);
        chk("b_cd_end", busy_out, 0);
        chk("b_drop_pos", position_out, 1);
        chk("b_drop_cash", cash_out, 900);
        chk("b_drop_rej", reject_count_out, 0);

        // Table-driven requests, each spaced past the cooldown
        do_reset();
        order_ready_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            req(vecs[i].sig, vecs[i].price, vecs[i].acc);
            repeat (11) tick();
            @(negedge clk);
            chk($sformatf("v%0d_pos", i), position_out, vecs[i].pos);
            chk($sformatf("v%0d_cash", i), cash_out, vecs[i].cash);
            chk($sformatf("v%0d_rej", i), reject_count_out, vecs[i].rej);
            chk($sformatf("v%0d_busy", i), busy_out, 0);
        end

        do_reset();
        order_ready_in = 1'b0;
`ifdef ORDER_TIMEOUT_EN
        // Ready never asserted: order abandoned after 16 cycles
        req(2'b01, 8'd50, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to_valid", order_valid_out, 1);
        end
        @(negedge clk);
        chk("to_valid_drop", order_valid_out, 0);
        chk("to_rej", reject_count_out, 1);
        chk("to_pos", position_out, 0);
        chk("to_cash", cash_out, 1000);
        chk("to_busy", busy_out, 0);
        sb.delete();
`else
        // Ready low for 20 cycles: order held stable, new request dropped
        req(2'b01, 8'd50, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", order_valid_out, 1);
            chk("hold_side", order_side_out, 0);
            chk("hold_price", order_price_out, 50);
            if (i == 5) begin
                price_valid_in = 1'b1;
                trade_signal_in = 2'b10;
                price_in = 8'd77;
            end else begin
                price_valid_in = 1'b0;
                trade_signal_in = 2'b00;
            end
        end
        @(posedge clk);
        #1;
        order_ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_valid_drop", order_valid_out, 0);
        chk("hold_pos", position_out, 1);
        chk("hold_cash", cash_out, 950);
        chk("hold_rej", reject_count_out, 0);
`endif

        // Reset in the middle of ISSUE abandons the pending order
        do_reset();
        order_ready_in = 1'b1;
        req(2'b01, 8'd100, 1'b1);
        repeat (11) tick();
        order_ready_in = 1'b0;
        req(2'b01, 8'd100, 1'b1);
        @(negedge clk);
        chk("mr_valid", order_valid_out, 1);
        chk("mr_pos_pre", position_out, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mr_valid_drop", order_valid_out, 0);
        chk("mr_cash", cash_out, 1000);
        chk("mr_pos", position_out, 0);
        chk("mr_busy", busy_out, 0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
